// File: rtl/vector_scalar_reduce_unit_pkg.sv
// Shared encodings for the vector scalar reduce unit.
// Op codes, frame-flag bit positions and a width helper.
package vector_scalar_reduce_unit_pkg;

  localparam logic [7:0] OP_PASS    = 8'd0;
  localparam logic [7:0] OP_SUM     = 8'd1;
  localparam logic [7:0] OP_ACC     = 8'd2;
  localparam logic [7:0] OP_SUM_ACC = 8'd3;

  localparam int EOF_BIT = 0;
  localparam int BOF_BIT = 0;

  function automatic int chain_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_scalar_reduce_unit_if.sv
// Vector stream bundle between the filter-reduce stage and
// the scalar reduce unit, plus the unit's result stream.
interface vector_scalar_reduce_unit_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  import vector_scalar_reduce_unit_pkg::*;

  localparam int CW = chain_w(MAX_CHAINS);

  logic                           valid_in;
  logic [1:0]                     eof_in;
  logic [1:0]                     bof_in;
  logic [CW-1:0]                  chainId_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;

  logic                           valid_out;
  logic [1:0]                     eof_out;
  logic [1:0]                     bof_out;
  logic [CW-1:0]                  chainId_out;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;

  modport master (
    output valid_in, eof_in, bof_in, chainId_in, vector_in,
    input  valid_out, eof_out, bof_out, chainId_out, vector_out
  );

  modport slave (
    input  valid_in, eof_in, bof_in, chainId_in, vector_in,
    output valid_out, eof_out, bof_out, chainId_out, vector_out
  );

endinterface

// File: rtl/vector_adder_tree.sv
// Combinational wrapping sum of all lanes of a vector.
// Sum is taken modulo 2^DATA_WIDTH.
module vector_adder_tree #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] lanes,
  output logic [DATA_WIDTH-1:0]        sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + lanes[i];
    end
  end

endmodule

// File: rtl/vector_scalar_reduce_unit.sv
// Per-chain vector reduce: passthrough, lane-sum, frame accumulate.
// Two-cycle pipeline; op table loaded over the config byte stream.
module vector_scalar_reduce_unit
  import vector_scalar_reduce_unit_pkg::*;
#(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 1,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_OP = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tracing,
  input  logic [7:0] configId,
  input  logic [7:0] configData,
  vector_scalar_reduce_unit_if.slave bus
);

  localparam int CW = chain_w(MAX_CHAINS);
  localparam int BW = $clog2(MAX_CHAINS + 1);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  logic [MAX_CHAINS-1:0][7:0] fw_op;
  logic [BW-1:0]              byte_cnt;
  logic                       cfg_hit;
  logic                       cfg_take;

  vec_t                  acc [MAX_CHAINS];

  logic                  s1_valid;
  logic [1:0]            s1_eof;
  logic [1:0]            s1_bof;
  logic [CW-1:0]         s1_chain;
  vec_t                  s1_vec;

  logic [7:0]            op;
  logic [DATA_WIDTH-1:0] lane_sum;
  vec_t                  acc_base;
  vec_t                  acc_new;
  vec_t                  nxt_vec;
  logic                  nxt_valid;
  logic                  acc_we;

  logic                  out_valid;
  logic [1:0]            out_eof;
  logic [1:0]            out_bof;
  logic [CW-1:0]         out_chain;
  vec_t                  out_vec;

  assign cfg_hit  = !tracing &&
                    (configId == 8'(PERSONAL_CONFIG_ID));
  assign cfg_take = cfg_hit &&
                    (byte_cnt < BW'(MAX_CHAINS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_op    <= INITIAL_FIRMWARE_OP;
      byte_cnt <= '0;
    end else if (cfg_take) begin
      fw_op[byte_cnt[CW-1:0]] <= configData;
      byte_cnt <= byte_cnt + 1'b1;
    end else if (!cfg_hit) begin
      byte_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eof   <= '0;
      s1_bof   <= '0;
      s1_chain <= '0;
      s1_vec   <= '0;
    end else begin
      s1_valid <= tracing & bus.valid_in;
      s1_eof   <= bus.eof_in;
      s1_bof   <= bus.bof_in;
      s1_chain <= bus.chainId_in;
      s1_vec   <= bus.vector_in;
    end
  end

  vector_adder_tree #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sum (
    .lanes (s1_vec),
    .sum   (lane_sum)
  );

  // Accumulators commit on the same edge the result registers,
  // so a same-chain follower in stage 1 already sees the update.
  always_comb begin
    op        = fw_op[s1_chain];
    acc_base  = s1_bof[BOF_BIT] ? '0 : acc[s1_chain];
    acc_new   = acc_base;
    nxt_vec   = s1_vec;
    nxt_valid = s1_valid;
    acc_we    = 1'b0;
    unique case (1'b1)
      op == OP_SUM: begin
        nxt_vec    = '0;
        nxt_vec[0] = lane_sum;
      end
      op == OP_ACC: begin
        for (int i = 0; i < N; i++) begin
          acc_new[i] = acc_base[i] + s1_vec[i];
        end
        nxt_vec   = acc_new;
        nxt_valid = s1_valid & s1_eof[EOF_BIT];
        acc_we    = s1_valid;
      end
      op == OP_SUM_ACC: begin
        acc_new    = '0;
        acc_new[0] = acc_base[0] + lane_sum;
        nxt_vec    = acc_new;
        nxt_valid  = s1_valid & s1_eof[EOF_BIT];
        acc_we     = s1_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < MAX_CHAINS; c++) acc[c] <= '0;
    end else if (cfg_take) begin
      for (int c = 0; c < MAX_CHAINS; c++) acc[c] <= '0;
    end else if (tracing && acc_we) begin
      acc[s1_chain] <= acc_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= '0;
      out_bof   <= '0;
      out_chain <= '0;
      out_vec   <= '0;
    end else begin
      out_valid <= tracing & nxt_valid;
      out_eof   <= s1_eof;
      out_bof   <= s1_bof;
      out_chain <= s1_chain;
      out_vec   <= nxt_vec;
    end
  end

  assign bus.valid_out   = out_valid;
  assign bus.eof_out     = out_eof;
  assign bus.bof_out     = out_bof;
  assign bus.chainId_out = out_chain;
  assign bus.vector_out  = out_vec;

endmodule

// File: tb/tb_vector_scalar_reduce_unit.sv
// Bench for vector_scalar_reduce_unit: directed cases plus random
// traffic checked against a per-vector reference model.
module tb_vector_scalar_reduce_unit;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int MC  = 4;
  localparam int CW  = 2;
  localparam int PID = 1;
  localparam logic [MC-1:0][7:0] INIT =
    {8'd1, 8'd3, 8'd2, 8'd2};

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef logic [N*DW-1:0]      wide_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tracing = 1'b0;
  logic [7:0] cfg_id = 8'd0;
  logic [7:0] cfg_data = 8'd0;

  int checks = 0;
  int errors = 0;

  vector_scalar_reduce_unit_if #(
    .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)
  ) bus ();

  vector_scalar_reduce_unit #(
    .N                  (N),
    .DATA_WIDTH         (DW),
    .MAX_CHAINS         (MC),
    .PERSONAL_CONFIG_ID (PID),
    .INITIAL_FIRMWARE_OP(INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .configId   (cfg_id),
    .configData (cfg_data),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] m_fw [MC];
  vec_t       m_acc [MC];
  int         m_cnt;
  logic       p_valid;
  vec_t       p_vec;
  logic [1:0] p_eof;
  logic [1:0] p_bof;
  logic [CW-1:0] p_ch;

  task automatic chk(input string tag, input wide_t obs,
                     input wide_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic vec_t fill(input logic [DW-1:0] v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int i = 0; i < N; i++) begin
      r[i] = ($urandom % 3 == 0) ? DW'($urandom_range(0, 20))
                                 : DW'($urandom);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < MC; c++) begin
      m_fw[c]  = INIT[c];
      m_acc[c] = '0;
    end
    m_cnt   = 0;
    p_valid = 1'b0;
    p_vec   = '0;
    p_eof   = '0;
    p_bof   = '0;
    p_ch    = '0;
  endtask

  task automatic chk_reset();
    chk("rst_vector_out", wide_t'(bus.vector_out), '0);
    chk("rst_valid_out", wide_t'(bus.valid_out), '0);
    chk("rst_eof_out", wide_t'(bus.eof_out), '0);
    chk("rst_bof_out", wide_t'(bus.bof_out), '0);
    chk("rst_chain_out", wide_t'(bus.chainId_out), '0);
  endtask

  // Predict the result of the inputs currently driven, clock once,
  // then compare against the result predicted one step earlier.
  task automatic step();
    vec_t       e_vec;
    logic       e_valid;
    logic [7:0] op;
    logic [DW-1:0] s;
    int         c;
    c       = int'(bus.chainId_in);
    e_valid = 1'b0;
    e_vec   = bus.vector_in;
    if (tracing) begin
      s = '0;
      for (int i = 0; i < N; i++) s = s + bus.vector_in[i];
      op = m_fw[c];
      if (op == 8'd1) begin
        e_vec    = '0;
        e_vec[0] = s;
        e_valid  = bus.valid_in;
      end else if (op == 8'd2 || op == 8'd3) begin
        if (bus.valid_in) begin
          if (bus.bof_in[0]) m_acc[c] = '0;
          if (op == 8'd2) begin
            for (int i = 0; i < N; i++)
              m_acc[c][i] = m_acc[c][i] + bus.vector_in[i];
          end else begin
            m_acc[c][0] = m_acc[c][0] + s;
          end
        end
        e_vec = m_acc[c];
        if (op == 8'd3) begin
          e_vec    = '0;
          e_vec[0] = m_acc[c][0];
        end
        e_valid = bus.valid_in && bus.eof_in[0];
      end else begin
        e_valid = bus.valid_in;
      end
    end else if (cfg_id == 8'(PID)) begin
      if (m_cnt < MC) begin
        m_fw[m_cnt] = cfg_data;
        m_cnt++;
        for (int k = 0; k < MC; k++) m_acc[k] = '0;
      end
    end else begin
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    chk("valid_out", wide_t'(bus.valid_out), wide_t'(p_valid));
    if (p_valid) begin
      chk("vector_out", wide_t'(bus.vector_out), wide_t'(p_vec));
      chk("eof_out", wide_t'(bus.eof_out), wide_t'(p_eof));
      chk("bof_out", wide_t'(bus.bof_out), wide_t'(p_bof));
      chk("chain_out", wide_t'(bus.chainId_out), wide_t'(p_ch));
    end
    p_valid = e_valid;
    p_vec   = e_vec;
    p_eof   = bus.eof_in;
    p_bof   = bus.bof_in;
    p_ch    = bus.chainId_in;
  endtask

  task automatic send(input logic v, input logic [CW-1:0] ch,
                      input logic b, input logic e,
                      input vec_t d);
    bus.valid_in   = v;
    bus.chainId_in = ch;
    bus.bof_in     = {1'($urandom % 2), b};
    bus.eof_in     = {1'($urandom % 2), e};
    bus.vector_in  = d;
    step();
  endtask

  task automatic idle();
    send(1'b0, CW'($urandom_range(0, MC - 1)), 1'b1, 1'b1,
         rnd_vec());
  endtask

  task automatic do_cfg(input logic [4:0][7:0] b, input int nb);
    idle();
    tracing       = 1'b0;
    cfg_id        = 8'd7;
    bus.valid_in  = 1'b1;
    bus.vector_in = rnd_vec();
    step();
    cfg_id = 8'(PID);
    for (int i = 0; i < nb; i++) begin
      cfg_data      = b[i];
      bus.valid_in  = 1'($urandom % 2);
      bus.eof_in    = 2'b11;
      bus.vector_in = rnd_vec();
      step();
    end
    cfg_id       = 8'd0;
    bus.valid_in = 1'b1;
    step();
    tracing = 1'b1;
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      send(1'($urandom % 4 != 0),
           CW'($urandom_range(0, MC - 1)),
           1'($urandom % 4 == 0), 1'($urandom % 4 == 0),
           rnd_vec());
    end
  endtask

  initial begin
    vec_t d;
    vec_t a;
    vec_t b;
    model_reset();
    bus.valid_in   = 1'b0;
    bus.eof_in     = '0;
    bus.bof_in     = '0;
    bus.chainId_in = '0;
    bus.vector_in  = '0;
    #12;
    chk_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    tracing = 1'b1;
    idle();

    for (int i = 0; i < N; i++) d[i] = DW'(i + 1);
    send(1'b1, 2'd3, 1'b0, 1'b0, d);
    idle();
    chk("lane_sum_36", wide_t'(bus.vector_out),
        wide_t'(vec_t'(36)));
    idle();

    send(1'b1, 2'd1, 1'b1, 1'b0, fill(32'd5));
    send(1'b1, 2'd1, 1'b0, 1'b0, fill(32'd5));
    send(1'b1, 2'd1, 1'b0, 1'b1, fill(32'd5));
    idle();
    chk("acc_all_15", wide_t'(bus.vector_out),
        wide_t'(fill(32'd15)));
    idle();

    for (int r = 0; r < 3; r++) begin
      send(1'b1, 2'd0, r == 0, r == 2, rnd_vec());
      send(1'b1, 2'd1, r == 0, r == 2, rnd_vec());
    end
    idle();
    idle();

    send(1'b1, 2'd0, 1'b1, 1'b0, fill(32'hFFFF_FFFF));
    send(1'b1, 2'd0, 1'b0, 1'b1, fill(32'd2));
    idle();
    chk("acc_wrap_1", wide_t'(bus.vector_out),
        wide_t'(fill(32'd1)));

    send(1'b1, 2'd1, 1'b1, 1'b0, fill(32'd9));
    do_cfg({8'd0, 8'd3, 8'd0, 8'd1, 8'd2}, 4);
    a = rnd_vec();
    send(1'b1, 2'd0, 1'b0, 1'b1, a);
    idle();
    chk("cfg_acc_cleared", wide_t'(bus.vector_out), wide_t'(a));
    b = rnd_vec();
    send(1'b1, 2'd1, 1'b0, 1'b0, b);
    idle();
    chk("cfg_op1_valid", wide_t'(bus.valid_out), wide_t'(1'b1));

    rand_phase(200);
    idle();

    do_cfg({8'd2, 8'd1, 8'd3, 8'd2, 8'd9}, 5);
    rand_phase(150);
    idle();

    send(1'b1, 2'd1, 1'b1, 1'b0, fill(32'd3));
    send(1'b1, 2'd1, 1'b0, 1'b0, fill(32'd3));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 2'd1, 1'b0, 1'b1, fill(32'd7));
    idle();
    chk("rst_midframe_7", wide_t'(bus.vector_out),
        wide_t'(fill(32'd7)));
    rand_phase(60);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_scalar_reduce_unit.md
VECTOR_SCALAR_REDUCE_UNIT -- requirements
Module: vector_scalar_reduce_unit

Interface
REQ-001 SHALL have parameter N, default 8, vector lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, lane width in bits.
REQ-003 SHALL have parameter MAX_CHAINS, default 4, number of chains.
REQ-004 SHALL have parameter PERSONAL_CONFIG_ID, default 1, configId this unit answers to.
REQ-005 SHALL have parameter INITIAL_FIRMWARE_OP, default all 0, per-chain 8-bit op table.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk input 1 (system clock, all logic on posedge); rst_n input 1 (asynchronous, active-low).
REQ-007 SHALL have port tracing, input, 1 bit: 1 = trace mode, 0 = configuration mode.
REQ-008 SHALL have ports valid_in input 1, eof_in input 2, bof_in input 2, and chainId_in input clog2(MAX_CHAINS): the upstream filter-reduce stage outputs.
REQ-009 SHALL have port vector_in, input, N x DATA_WIDTH: input vector.
REQ-010 SHALL have ports configId input 8 and configData input 8: configuration byte stream.
REQ-011 SHALL have ports vector_out output N x DATA_WIDTH, valid_out output 1, eof_out output 2, bof_out output 2, and chainId_out output clog2(MAX_CHAINS).

Function
REQ-012 SHALL select the op per vector as firmware_op[chainId_in]: 0 = passthrough, 1 = lane-sum, 2 = frame accumulate, 3 = lane-sum accumulate; other values SHALL behave as 0.
REQ-013 SHALL have a fixed latency of exactly 2 cycles from valid_in to valid_out for every op, with eof, bof and chainId delayed alongside the data.
REQ-014 Op 0 SHALL output vector_in unchanged, with valid_out = valid_in delayed.
REQ-015 Op 1 SHALL output lane 0 = sum of all N lanes mod 2^DATA_WIDTH and lanes 1..N-1 = 0, with valid_out = valid_in delayed.
REQ-016 Op 2 SHALL keep one N-lane accumulator per chain.
REQ-017 In op 2, a valid vector with bof_in[0]=1 SHALL load the accumulator with that vector; otherwise it SHALL add the vector lane-wise, mod 2^DATA_WIDTH.
REQ-018 In op 2, valid_out SHALL be 1 only for a vector with eof_in[0]=1, and vector_out SHALL be the accumulator including that vector; all other vectors SHALL produce valid_out=0.
REQ-019 Op 3 SHALL behave as op 2 applied to the op-1 result: lane-0 accumulator, other lanes 0.
REQ-020 In ops 2 and 3, bof_in[0]=1 and eof_in[0]=1 on the same vector SHALL emit that vector's own value (op 2) or its lane-sum (op 3).
REQ-021 Two consecutive valid vectors of the same chain SHALL accumulate correctly back-to-back, without bubbles, via a forwarding path.
REQ-022 Vectors with valid_in=0 SHALL leave all accumulators unchanged.
REQ-023 When tracing=0, valid_out SHALL be 0.
REQ-024 When tracing=0 and configId==PERSONAL_CONFIG_ID, each cycle SHALL write configData to firmware_op[byte_counter] while byte_counter < MAX_CHAINS, then increment byte_counter; bytes beyond that SHALL be ignored.
REQ-025 When tracing=0 and configId differs from PERSONAL_CONFIG_ID, byte_counter SHALL return to 0.
REQ-026 Any accepted config byte SHALL clear all accumulators.
REQ-027 Pipeline registers SHALL flush to valid=0 while tracing=0, so that no stale output appears on return to tracing.

Reset
REQ-028 On rst_n=0, outputs SHALL be: vector_out 0, valid_out 0, eof_out 0, bof_out 0, chainId_out 0.
REQ-029 On rst_n=0, accumulators, pipeline valids and byte_counter SHALL be 0, and firmware_op SHALL return to INITIAL_FIRMWARE_OP.
REQ-030 Reset asserted mid-frame SHALL discard the partial accumulation; the first vector after release is treated as if preceded by bof.

Structure
REQ-031 A shared package SHALL hold the op encodings (OP_PASS, OP_SUM, OP_ACC, OP_SUM_ACC) and the eof/bof bit-index constants.
REQ-032 A combinational lane-sum sub-module, vector_adder_tree, SHALL be used (N inputs, DATA_WIDTH output, wrapping).

Verification
REQ-033 Op 1, N=8, vector 1..8 -> two cycles later valid_out=1, lane0=36, other lanes 0.
REQ-034 Op 2, chain 1: three vectors of all-5 with bof on the first and eof on the third -> a single output of all-15 two cycles after the third; no output for the first two.
REQ-035 Op 2, interleaved chains 0 and 1, back-to-back vectors -> each chain's output equals its own sum and never includes the other chain.
REQ-036 Op 2, lanes 0xFFFFFFFF + 2 with DATA_WIDTH=32 -> output lane 1 (wrap-around).
REQ-037 Configuration: tracing=0, configId matched, bytes {2,1,0,3} -> firmware_op = {2,1,0,3}, accumulators 0, and valid_out held at 0 throughout.
REQ-038 Reset mid-frame after two accumulated vectors, then a vector of 7 with eof -> output 7.
